// File: rtl/vga_console_pkg.sv
// Shared constants, control codes and state type for the text console writer.
package vga_console_pkg;

  localparam int NUM_ROWS_DEF = 3;
  localparam int NUM_COLS_DEF = 10;
  localparam int NUM_CHARS    = NUM_ROWS_DEF * NUM_COLS_DEF;

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;

  localparam logic [8:0] BLANK_CELL = 9'h020;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CLEAR
  } state_t;

  function automatic logic is_printable(logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/vga_console_cursor.sv
// Row/column cursor for the console; flags a newline on the last row.
module vga_console_cursor #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       newline,
  input  logic       cr,
  input  logic       bs,
  input  logic       home,
  output logic [1:0] row,
  output logic [3:0] col,
  output logic       scroll_req
);

  localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

  logic wrap;

  assign wrap       = newline | (advance & (col == LAST_COL));
  assign scroll_req = wrap & (row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (home) begin
      row <= '0;
      col <= '0;
    end else if (wrap) begin
      col <= '0;
      if (row != LAST_ROW)
        row <= row + 2'd1;
    end else if (advance) begin
      col <= col + 4'd1;
    end else if (cr) begin
      col <= '0;
    end else if (bs && col != '0) begin
      col <= col - 4'd1;
    end
  end

endmodule

// File: rtl/vga_console_writer.sv
// Character stream to text-buffer writer with scroll-up and clear sequencing.
module vga_console_writer
  import vga_console_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int NUM_COLS = NUM_COLS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_char,
  input  logic [1:0] in_color,
  output logic [4:0] buf_waddr,
  output logic [8:0] buf_wdata,
  output logic       buf_we,
  output logic [4:0] buf_raddr,
  input  logic [8:0] buf_rdata,
  output logic [1:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  localparam int CHARS = NUM_ROWS * NUM_COLS;
  localparam logic [4:0] LAST_COPY = 5'(CHARS - NUM_COLS - 1);
  localparam logic [4:0] ROW_LAST0 = 5'(CHARS - NUM_COLS);
  localparam logic [4:0] LAST_CHAR = 5'(CHARS - 1);
  localparam logic [4:0] COLS5     = 5'(NUM_COLS);

  state_t     state;
  logic [4:0] idx;
  logic [4:0] cur_addr;
  logic       accept;
  logic       adv, nl, cr, bs, home, wr;
  logic       scroll_req;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign cur_addr = 5'(int'(cursor_row) * NUM_COLS + int'(cursor_col));

  always_comb begin
    adv  = 1'b0;
    nl   = 1'b0;
    cr   = 1'b0;
    bs   = 1'b0;
    home = 1'b0;
    wr   = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_printable(in_char): begin
          adv = 1'b1;
          wr  = 1'b1;
        end
        in_char == CH_LF: nl   = 1'b1;
        in_char == CH_CR: cr   = 1'b1;
        in_char == CH_BS: bs   = 1'b1;
        in_char == CH_FF: home = 1'b1;
        default: ;
      endcase
    end
  end

  vga_console_cursor #(
    .NUM_ROWS(NUM_ROWS),
    .NUM_COLS(NUM_COLS)
  ) u_cursor (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (adv),
    .newline   (nl),
    .cr        (cr),
    .bs        (bs),
    .home      (home),
    .row       (cursor_row),
    .col       (cursor_col),
    .scroll_req(scroll_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      buf_raddr <= '0;
    end else begin
      buf_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr) begin
            buf_we    <= 1'b1;
            buf_waddr <= cur_addr;
            buf_wdata <= {in_color, in_char};
          end
          if (home) begin
            state <= CLEAR;
            idx   <= '0;
          end else if (scroll_req) begin
            state     <= SCROLL;
            idx       <= '0;
            buf_raddr <= COLS5;
          end
        end
        SCROLL: begin
          // raddr was set one cycle ahead, so rdata is the source for idx
          buf_we    <= 1'b1;
          buf_waddr <= idx;
          buf_wdata <= buf_rdata;
          if (idx == LAST_COPY) begin
            state     <= CLEAR;
            idx       <= ROW_LAST0;
            buf_raddr <= '0;
          end else begin
            idx       <= idx + 5'd1;
            buf_raddr <= idx + 5'd1 + COLS5;
          end
        end
        CLEAR: begin
          buf_we    <= 1'b1;
          buf_waddr <= idx;
          buf_wdata <= BLANK_CELL;
          if (idx == LAST_CHAR) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
